// File: rtl/io_interval_timer.sv
// io_interval_timer: io-bus interval timer with prescaler, sticky expiry flag and level irq.
// Optional 64-bit cycle counter at +0x14/+0x18 when IO_INTERVAL_TIMER_CYCLE_COUNTER_EN is defined.
module io_interval_timer #(
    parameter logic [31:0] BASE_ADDRESS   = 32'h30,
    parameter int          PRESCALE_WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_write_en,
    input  logic        io_read_en,
    input  logic [31:0] io_address,
    input  logic [31:0] io_write_data,
    output logic [31:0] io_read_data,
    output logic        timer_irq
);
    logic [31:0] w_off, w_rdata;
    logic [2:0]  w_idx;
    logic        w_hit, w_wr, w_wr_ctrl, w_wr_reload, w_wr_count, w_wr_status, w_wr_presc;
    logic        w_tick, w_expire, w_en_rise;
    logic        r_enable, r_auto, r_irq_en, r_expired;
    logic [31:0] r_reload, r_count, r_rdata;
    logic [PRESCALE_WIDTH-1:0] r_prescale, r_pcnt;

    assign w_off       = io_address - BASE_ADDRESS;
    assign w_hit       = (w_off < 32'h20) && (w_off[1:0] == 2'b00);
    assign w_idx       = w_off[4:2];
    assign w_wr        = io_write_en && w_hit;
    assign w_wr_ctrl   = w_wr && (w_idx == 3'd0);
    assign w_wr_reload = w_wr && (w_idx == 3'd1);
    assign w_wr_count  = w_wr && (w_idx == 3'd2);
    assign w_wr_status = w_wr && (w_idx == 3'd3);
    assign w_wr_presc  = w_wr && (w_idx == 3'd4);
    assign w_tick      = r_enable && (r_pcnt == '0);
    assign w_expire    = w_tick && (r_count == 32'd0);
    assign w_en_rise   = w_wr_ctrl && io_write_data[0] && !r_enable;
    assign io_read_data = r_rdata;
    assign timer_irq    = r_expired && r_irq_en;

`ifdef IO_INTERVAL_TIMER_CYCLE_COUNTER_EN
    logic [63:0] r_cyc;
    logic [31:0] r_shadow;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cyc    <= 64'd0;
            r_shadow <= 32'd0;
        end else begin
            r_cyc <= r_cyc + 64'd1;
            if (io_read_en && w_hit && (w_idx == 3'd5)) r_shadow <= r_cyc[63:32];
        end
    end
`else
    logic w_unused;
    assign w_unused = io_read_en;
`endif

    always_comb begin
        w_rdata = 32'd0;
        if (w_hit) begin
            case (w_idx)
                3'd0:    w_rdata = {29'd0, r_irq_en, r_auto, r_enable};
                3'd1:    w_rdata = r_reload;
                3'd2:    w_rdata = r_count;
                3'd3:    w_rdata = {31'd0, r_expired};
                3'd4:    w_rdata = {{(32-PRESCALE_WIDTH){1'b0}}, r_prescale};
`ifdef IO_INTERVAL_TIMER_CYCLE_COUNTER_EN
                3'd5:    w_rdata = r_cyc[31:0];
                3'd6:    w_rdata = r_shadow;
`endif
                default: w_rdata = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_enable   <= 1'b0;
            r_auto     <= 1'b0;
            r_irq_en   <= 1'b0;
            r_expired  <= 1'b0;
            r_reload   <= 32'd0;
            r_count    <= 32'd0;
            r_rdata    <= 32'd0;
            r_prescale <= '0;
            r_pcnt     <= '0;
        end else begin
            r_rdata <= w_rdata;
            if (w_wr_ctrl) begin
                r_enable <= io_write_data[0];
                r_auto   <= io_write_data[1];
                r_irq_en <= io_write_data[2];
            end else if (w_expire && !r_auto) begin
                r_enable <= 1'b0;
            end
            if (w_wr_reload) r_reload <= io_write_data;
            if (w_wr_presc) r_prescale <= io_write_data[PRESCALE_WIDTH-1:0];
            // a COUNT write discards a coincident tick; expiry reloads from the pre-edge reload value
            if (w_wr_count) r_count <= io_write_data;
            else if (w_tick) r_count <= (r_count != 32'd0) ? r_count - 32'd1 : (r_auto ? r_reload : 32'd0);
            if (w_wr_count || w_en_rise) r_pcnt <= r_prescale;
            else if (r_enable) r_pcnt <= (r_pcnt == '0) ? r_prescale : r_pcnt - PRESCALE_WIDTH'(1);
            if (w_expire) r_expired <= 1'b1;
            else if (w_wr_status && io_write_data[0]) r_expired <= 1'b0;
        end
    end
endmodule

// File: tb/tb_io_interval_timer.sv
// tb_io_interval_timer: register-map vectors plus timing sequences for period, one-shot,
// W1C-vs-set, COUNT-write-vs-tick and asynchronous reset.
module tb_io_interval_timer;
    localparam logic [31:0] B = 32'h30;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
        string       nm;
    } vec_t;

    logic        clk = 1'b0, reset = 1'b1;
    logic        io_write_en = 1'b0, io_read_en = 1'b0;
    logic [31:0] io_address = 32'd0, io_write_data = 32'd0;
    logic [31:0] io_read_data;
    logic        timer_irq;
    int          n_tests = 0, n_fail = 0;
    logic [31:0] exp_q[$];
    string       nm_q[$];
    vec_t        vt[$];

    io_interval_timer dut (
        .clk(clk), .reset(reset), .io_write_en(io_write_en), .io_read_en(io_read_en),
        .io_address(io_address), .io_write_data(io_write_data),
        .io_read_data(io_read_data), .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        io_address = a;
        io_write_data = d;
        io_write_en = 1'b1;
        step();
        io_write_en = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e, input string nm);
        io_address = a;
        io_read_en = 1'b1;
        exp_q.push_back(e);
        nm_q.push_back(nm);
        step();
        io_read_en = 1'b0;
        chk(nm_q.pop_front(), io_read_data, exp_q.pop_front());
    endtask

    initial begin
        vt.push_back('{0, B+32'h00, 32'h0, "rst_ctrl"});
        vt.push_back('{0, B+32'h04, 32'h0, "rst_reload"});
        vt.push_back('{0, B+32'h08, 32'h0, "rst_count"});
        vt.push_back('{0, B+32'h0C, 32'h0, "rst_status"});
        vt.push_back('{0, B+32'h10, 32'h0, "rst_presc"});
        vt.push_back('{0, B+32'h20, 32'h0, "out_hi"});
        vt.push_back('{0, 32'h0,    32'h0, "out_zero"});
        vt.push_back('{1, B+32'h04, 32'hDEADBEEF, ""});
        vt.push_back('{1, B+32'h10, 32'h00012345, ""});
        vt.push_back('{1, B+32'h00, 32'hFFFFFFF6, ""});
        vt.push_back('{1, B+32'h08, 32'hFFFFFFFF, ""});
        vt.push_back('{1, B+32'h0C, 32'hFFFFFFFF, ""});
        vt.push_back('{1, 32'h28,   32'h5A5A5A5A, ""});
        vt.push_back('{0, B+32'h00, 32'h00000006, "ctrl_rb"});
        vt.push_back('{0, B+32'h04, 32'hDEADBEEF, "reload_rb"});
        vt.push_back('{0, B+32'h08, 32'hFFFFFFFF, "count_rb"});
        vt.push_back('{0, B+32'h0C, 32'h0, "status_rb"});
        vt.push_back('{0, B+32'h10, 32'h00002345, "presc_zext"});
        vt.push_back('{0, B+32'h1C, 32'h0, "unmapped_1c"});
`ifndef IO_INTERVAL_TIMER_CYCLE_COUNTER_EN
        vt.push_back('{0, B+32'h14, 32'h0, "cyc_lo_off"});
        vt.push_back('{0, B+32'h18, 32'h0, "cyc_hi_off"});
`endif

        repeat (3) @(posedge clk);
        chk("irq_in_reset", {31'd0, timer_irq}, 32'd0);
        #1 reset = 1'b0;
        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].we) wr(vt[i].addr, vt[i].data);
            else rd(vt[i].addr, vt[i].data, vt[i].nm);
        end
        chk("irq_no_expiry", {31'd0, timer_irq}, 32'd0);

        // auto-reload period of 5 clocks
        wr(B+32'h00, 32'h0);
        wr(B+32'h10, 32'd0);
        wr(B+32'h04, 32'd4);
        wr(B+32'h08, 32'd4);
        wr(B+32'h00, 32'h7);
        repeat (4) step();
        chk("auto_pre_irq", {31'd0, timer_irq}, 32'd0);
        step();
        chk("auto_irq", {31'd0, timer_irq}, 32'd1);
        rd(B+32'h08, 32'd4, "count_after_reload");
        wr(B+32'h0C, 32'h1);
        chk("w1c_clear", {31'd0, timer_irq}, 32'd0);
        repeat (2) step();
        chk("period2_pre", {31'd0, timer_irq}, 32'd0);
        step();
        chk("period2_irq", {31'd0, timer_irq}, 32'd1);
        wr(B+32'h00, 32'h0);

        // one-shot, prescale 2, expiry 6 clocks after enable
        wr(B+32'h0C, 32'h1);
        wr(B+32'h10, 32'd2);
        wr(B+32'h08, 32'd1);
        wr(B+32'h00, 32'h1);
        repeat (5) step();
        rd(B+32'h0C, 32'd0, "oneshot_before");
        rd(B+32'h0C, 32'd1, "oneshot_expired");
        rd(B+32'h00, 32'd0, "oneshot_ctrl");
        rd(B+32'h08, 32'd0, "oneshot_count");
        chk("oneshot_no_irq", {31'd0, timer_irq}, 32'd0);

        // expiry every clock: set beats W1C
        wr(B+32'h10, 32'd0);
        wr(B+32'h04, 32'd0);
        wr(B+32'h08, 32'd0);
        wr(B+32'h00, 32'h3);
        repeat (5) wr(B+32'h0C, 32'h1);
        rd(B+32'h0C, 32'd1, "set_beats_clear");
        wr(B+32'h00, 32'h0);
        rd(B+32'h00, 32'd0, "ctrl_write_wins");
        wr(B+32'h0C, 32'h1);
        rd(B+32'h0C, 32'd0, "clear_when_idle");

        // COUNT write beats a coincident tick
        wr(B+32'h08, 32'd10);
        wr(B+32'h00, 32'h1);
        wr(B+32'h08, 32'd100);
        rd(B+32'h08, 32'd100, "count_write_wins");
        rd(B+32'h08, 32'd99, "count_ticks_on");
        wr(B+32'h00, 32'h0);

        // asynchronous reset mid-count with irq asserted
        wr(B+32'h04, 32'd1);
        wr(B+32'h08, 32'd0);
        wr(B+32'h00, 32'h7);
        step();
        chk("pre_reset_irq", {31'd0, timer_irq}, 32'd1);
        #2 reset = 1'b1;
        #1 chk("async_reset_irq", {31'd0, timer_irq}, 32'd0);
        step();
        reset = 1'b0;
        rd(B+32'h00, 32'd0, "post_rst_ctrl");
        rd(B+32'h04, 32'd0, "post_rst_reload");
        rd(B+32'h08, 32'd0, "post_rst_count");
        rd(B+32'h0C, 32'd0, "post_rst_status");

`ifdef IO_INTERVAL_TIMER_CYCLE_COUNTER_EN
        wr(B+32'h14, 32'hFFFFFFFF);
        io_address = B + 32'h14;
        io_read_en = 1'b1;
        step();
        io_read_en = 1'b0;
        n_tests++;
        if (io_read_data == 32'd0) begin
            n_fail++;
            $display("FAIL cyc_lo: got %h expected nonzero", io_read_data);
        end
        rd(B+32'h18, 32'd0, "cyc_hi");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
